// File: rtl/draw_datapath.sv
// Command responder for the drawing FSMs: accepts one instruction per start edge and
// executes NOP / single-pixel DRAW / rectangle FILL / RAND, driving the VGA pixel port.
module draw_datapath #(
  parameter int OPCODE_WIDTH      = 4,
  parameter int X_COORD_WIDTH     = 8,
  parameter int Y_COORD_WIDTH     = 7,
  parameter int COLOUR_WIDTH      = 3,
  parameter int SCREEN_WIDTH      = 160,
  parameter int SCREEN_HEIGHT     = 120,
  parameter int INSTRUCTION_WIDTH = 48,
  parameter int RESULT_WIDTH      = 32
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         start,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         finished,
  output logic [RESULT_WIDTH-1:0]      result,
  output logic [X_COORD_WIDTH-1:0]     vga_x,
  output logic [Y_COORD_WIDTH-1:0]     vga_y,
  output logic [COLOUR_WIDTH-1:0]      vga_colour,
  output logic                         vga_plot
);

  localparam int X_LSB = OPCODE_WIDTH;
  localparam int Y_LSB = X_LSB + X_COORD_WIDTH;
  localparam int C_LSB = Y_LSB + Y_COORD_WIDTH;
  localparam int P_BIT = C_LSB + COLOUR_WIDTH;
  localparam int W_LSB = P_BIT + 1;
  localparam int H_LSB = W_LSB + X_COORD_WIDTH;
  localparam int CMD_W = H_LSB + Y_COORD_WIDTH;

  localparam logic [X_COORD_WIDTH:0] SW = (X_COORD_WIDTH+1)'(SCREEN_WIDTH);
  localparam logic [Y_COORD_WIDTH:0] SH = (Y_COORD_WIDTH+1)'(SCREEN_HEIGHT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]               state;
  logic                     start_prev;
  logic [15:0]              lfsr;
  logic [CMD_W-1:0]         cmd;
  logic [X_COORD_WIDTH:0]   cx;
  logic [Y_COORD_WIDTH:0]   cy;
  logic [RESULT_WIDTH-1:0]  count;

  generate
    if (INSTRUCTION_WIDTH > CMD_W) begin : g_spare
      logic unused_bits;
      assign unused_bits = ^instruction[INSTRUCTION_WIDTH-1:CMD_W];
    end
  endgenerate

  logic [OPCODE_WIDTH-1:0]  c_op;
  logic [X_COORD_WIDTH-1:0] c_x, c_w;
  logic [Y_COORD_WIDTH-1:0] c_y, c_h;
  logic [COLOUR_WIDTH-1:0]  c_col;
  logic                     c_plot;

  assign c_op   = cmd[X_LSB-1:0];
  assign c_x    = cmd[Y_LSB-1:X_LSB];
  assign c_y    = cmd[C_LSB-1:Y_LSB];
  assign c_col  = cmd[P_BIT-1:C_LSB];
  assign c_plot = cmd[P_BIT];
  assign c_w    = cmd[H_LSB-1:W_LSB];
  assign c_h    = cmd[CMD_W-1:H_LSB];

  // Counters are one bit wider than the fields so x+w-1 / y+h-1 never wrap.
  logic [X_COORD_WIDTH:0]  x_last;
  logic [Y_COORD_WIDTH:0]  y_last;
  logic                    fill_on, draw_on;
  logic [RESULT_WIDTH-1:0] count_next;
  logic                    lfsr_fb;

  assign x_last     = {1'b0, c_x} + {1'b0, c_w} - 1'b1;
  assign y_last     = {1'b0, c_y} + {1'b0, c_h} - 1'b1;
  assign fill_on    = c_plot && (cx < SW) && (cy < SH);
  assign draw_on    = c_plot && ({1'b0, c_x} < SW) && ({1'b0, c_y} < SH);
  assign count_next = count + {{(RESULT_WIDTH-1){1'b0}}, fill_on};
  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      start_prev <= 1'b0;
      lfsr       <= 16'hACE1;
      cmd        <= '0;
      cx         <= '0;
      cy         <= '0;
      count      <= '0;
      finished   <= 1'b1;
      result     <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      start_prev <= start;
      lfsr       <= {lfsr[14:0], lfsr_fb};
      case (state)
        S_IDLE: begin
          vga_plot <= 1'b0;
          if (start && !start_prev) begin
            cmd      <= instruction[CMD_W-1:0];
            finished <= 1'b0;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          state <= S_DONE;
          case (c_op)
            OPCODE_WIDTH'(0): result <= '0;
            OPCODE_WIDTH'(1): begin
              vga_x      <= c_x;
              vga_y      <= c_y;
              vga_colour <= c_col;
              vga_plot   <= draw_on;
              result     <= '0;
            end
            OPCODE_WIDTH'(2): begin
              if (c_w == '0 || c_h == '0) begin
                result <= '0;
              end else begin
                cx    <= {1'b0, c_x};
                cy    <= {1'b0, c_y};
                count <= '0;
                state <= S_FILL;
              end
            end
            OPCODE_WIDTH'(3): result <= {{(RESULT_WIDTH-16){1'b0}}, lfsr};
            default:          result <= '1;
          endcase
        end
        S_FILL: begin
          vga_x      <= cx[X_COORD_WIDTH-1:0];
          vga_y      <= cy[Y_COORD_WIDTH-1:0];
          vga_colour <= c_col;
          vga_plot   <= fill_on;
          count      <= count_next;
          if (cx == x_last) begin
            cx <= {1'b0, c_x};
            if (cy == y_last) begin
              result <= count_next;
              state  <= S_DONE;
            end else begin
              cy <= cy + 1'b1;
            end
          end else begin
            cx <= cx + 1'b1;
          end
        end
        S_DONE: begin
          vga_plot <= 1'b0;
          finished <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_datapath.sv
// Directed bench for draw_datapath: command driver, pixel scoreboard, assertion checks.
module tb_draw_datapath;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [47:0] instruction = '0;
  logic        finished;
  logic [31:0] result;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  int vectors = 0;
  int miscompares = 0;
  int plot_cnt = 0;
  logic [17:0] exp_q[$];

  draw_datapath dut (
    .clock(clock), .resetn(resetn), .start(start), .instruction(instruction),
    .finished(finished), .result(result), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clock = ~clock;

  // Every plotted pixel must match the head of the expected queue.
  always @(negedge clock) begin
    logic [17:0] got, exp;
    if (resetn && vga_plot) begin
      plot_cnt++;
      got = {vga_x, vga_y, vga_colour};
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3FFFF;
      vectors++;
      assert (got === exp) else begin
        miscompares++;
        $error("FAIL pixel got %h exp %h", got, exp);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] mk(input logic [3:0] op, input logic [7:0] x,
                                     input logic [6:0] y, input logic [2:0] c, input logic p,
                                     input logic [7:0] w, input logic [6:0] h);
    logic [9:0] junk;
    junk = 10'($urandom_range(0, 1023));
    return {junk, h, w, p, c, y, x, op};
  endfunction

  // Raise start for two sampled cycles; lat = cycles finished stays low after accept.
  task automatic send(input logic [47:0] ins, output int lat);
    bit done;
    @(posedge clock); #1;
    instruction = ins;
    start = 1'b1;
    @(posedge clock);
    lat = 0;
    done = 0;
    for (int i = 0; i < 40000; i++) begin
      @(negedge clock);
      if (finished) begin
        done = 1;
        break;
      end
      lat++;
      if (lat == 2) start = 1'b0;
    end
    start = 1'b0;
    check("finish_timeout", done, 1'b1);
  endtask

  task automatic push_px(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    exp_q.push_back({x, y, c});
  endtask

  initial begin
    int lat, p0;
    logic [31:0] r1, r2;
    int rows[8] = '{0, 1, 2, 3, 116, 117, 118, 119};

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_finished", finished, 1'b1);
    check("rst_result", result, 32'h0);
    check("rst_plot", vga_plot, 1'b0);
    check("rst_xyc", {vga_x, vga_y, vga_colour}, 18'h0);
    resetn = 1'b1;

    // DRAW with start held two cycles
    send(mk(4'd9, 0, 0, 0, 0, 0, 0), lat);
    check("op9_result", result, 32'hFFFFFFFF);
    check("op9_lat", lat, 2);
    p0 = plot_cnt;
    push_px(8'd5, 7'd7, 3'd3);
    send(mk(4'd1, 8'd5, 7'd7, 3'd3, 1'b1, 0, 0), lat);
    check("draw_lat", lat, 2);
    check("draw_result", result, 32'h0);
    repeat (6) @(negedge clock);
    check("draw_once", plot_cnt - p0, 1);
    check("draw_idle_fin", finished, 1'b1);

    // DRAW off-screen and DRAW with plot=0
    p0 = plot_cnt;
    send(mk(4'd1, 8'd160, 7'd7, 3'd1, 1'b1, 0, 0), lat);
    send(mk(4'd1, 8'd3, 7'd120, 3'd1, 1'b1, 0, 0), lat);
    send(mk(4'd1, 8'd3, 7'd4, 3'd1, 1'b0, 0, 0), lat);
    check("draw_clip", plot_cnt - p0, 0);

    // FILL at the bottom-right corner, half off-screen
    p0 = plot_cnt;
    push_px(8'd158, 7'd118, 3'd5);
    push_px(8'd159, 7'd118, 3'd5);
    push_px(8'd158, 7'd119, 3'd5);
    push_px(8'd159, 7'd119, 3'd5);
    send(mk(4'd2, 8'd158, 7'd118, 3'd5, 1'b1, 8'd4, 7'd4), lat);
    check("fill_lat", lat, 18);
    check("fill_result", result, 32'd4);
    check("fill_plots", plot_cnt - p0, 4);

    // FILL with zero width
    send(mk(4'd9, 0, 0, 0, 0, 0, 0), lat);
    p0 = plot_cnt;
    send(mk(4'd2, 8'd10, 7'd10, 3'd2, 1'b1, 8'd0, 7'd5), lat);
    check("fill0_lat", lat, 2);
    check("fill0_result", result, 32'h0);
    check("fill0_plots", plot_cnt - p0, 0);

    // RAND twice and unknown opcode
    send(mk(4'd3, 0, 0, 0, 0, 0, 0), lat);
    r1 = result;
    send(mk(4'd3, 0, 0, 0, 0, 0, 0), lat);
    r2 = result;
    check("rand_nonzero", r1 != 32'h0, 1'b1);
    check("rand_upper", r2[31:16], 16'h0);
    check("rand_differ", r1 != r2, 1'b1);
    p0 = plot_cnt;
    send(mk(4'd9, 8'd5, 8'd5, 3'd1, 1'b1, 8'd3, 7'd3), lat);
    check("op9b_result", result, 32'hFFFFFFFF);
    check("op9b_plots", plot_cnt - p0, 0);

    // Background-style sweep over top and bottom rows
    p0 = plot_cnt;
    foreach (rows[r]) begin
      for (int x = 0; x < 160; x++) begin
        push_px(8'(x), 7'(rows[r]), 3'((x + rows[r]) % 8));
        send(mk(4'd1, 8'(x), 7'(rows[r]), 3'((x + rows[r]) % 8), 1'b1, 0, 0), lat);
        check("sweep_lat", lat, 2);
      end
    end
    check("sweep_plots", plot_cnt - p0, 1280);
    check("sweep_q_empty", exp_q.size(), 0);

    // Reset in the middle of a FILL, right after its 37th pixel
    send(mk(4'd9, 0, 0, 0, 0, 0, 0), lat);
    for (int i = 0; i < 37; i++) push_px(8'(10 + i % 20), 7'(10 + i / 20), 3'd6);
    @(posedge clock); #1;
    instruction = mk(4'd2, 8'd10, 7'd10, 3'd6, 1'b1, 8'd20, 7'd10);
    start = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    start = 1'b0;
    begin
      bit hit;
      hit = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clock); #1;
        if (exp_q.size() == 0) begin
          hit = 1;
          break;
        end
      end
      check("fill_37_reached", hit, 1'b1);
    end
    resetn = 1'b0;
    #1;
    check("mid_rst_finished", finished, 1'b1);
    check("mid_rst_plot", vga_plot, 1'b0);
    check("mid_rst_result", result, 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    exp_q.delete();
    p0 = plot_cnt;
    send(mk(4'd0, 0, 0, 0, 0, 0, 0), lat);
    check("post_rst_nop_lat", lat, 2);
    check("post_rst_nop_result", result, 32'h0);
    check("post_rst_plots", plot_cnt - p0, 0);

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/draw_datapath.md
Name: draw_datapath

Overview:
- Responder end of the start/instruction/finished/result command handshake used by the drawing control FSMs, such as the background clear.
- Accepts one instruction at a time, decodes the opcode and executes it.
- Draw operations drive the VGA adapter's pixel-write port; the block then returns finished plus a result word.
- Sits between the drawing-control FSMs, muxed in by the top level, and the VGA adapter.

Parameters:
- OPCODE_WIDTH, 4, opcode field width.
- X_COORD_WIDTH, 8, x field and vga_x width.
- Y_COORD_WIDTH, 7, y field and vga_y width.
- COLOUR_WIDTH, 3, colour field and vga_colour width.
- SCREEN_WIDTH, 160, visible columns.
- SCREEN_HEIGHT, 120, visible rows.
- INSTRUCTION_WIDTH, 48, instruction bus width; must be at least 38.
- RESULT_WIDTH, 32, result bus width.

Ports:
- clock  in  1  system clock; single clock domain.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  command request from initiator; held high for 2 cycles.
- instruction  in  INSTRUCTION_WIDTH  {h[37:31], w[30:23], plot[22], colour[21:19], y[18:12], x[11:4], opcode[3:0]}; bits above 37 are ignored.
- finished  out  1  high = idle, result valid.
- result  out  RESULT_WIDTH  result of the last completed command.
- vga_x  out  X_COORD_WIDTH  pixel x.
- vga_y  out  Y_COORD_WIDTH  pixel y.
- vga_colour  out  COLOUR_WIDTH  pixel colour.
- vga_plot  out  1  pixel write enable; one pixel per cycle when high.

Behaviour:
- Reset (asynchronous, any state, including mid-FILL):
  - state=IDLE, finished=1, result=0, vga_plot=0, vga_x/vga_y/vga_colour=0.
  - start_prev=0, lfsr=16'hACE1.
- Accept rule:
  - In IDLE, a command is accepted at the edge where start=1 and start_prev=0. start_prev is start registered every cycle.
  - The second high cycle of start never re-triggers.
  - start is ignored outside IDLE.
- On accept edge:
  - Latch instruction into cmd register.
  - finished<=0, state<=EXEC.
- EXEC, one cycle, by opcode:
  - 0 NOP: result<=0; go to DONE.
  - 1 DRAW:
    - vga_x/y/colour<=fields, vga_plot<=plot bit, for exactly one cycle.
    - result<=0; go to DONE.
    - Coordinates outside the screen force vga_plot<=0 (no wrap).
  - 2 FILL:
    - Init cx=x, cy=y, count=0; go to FILL.
    - If w=0 or h=0, result<=0 and go to DONE.
  - 3 RAND: result<=zero-extended lfsr value sampled in EXEC; go to DONE.
  - Others: result<=all ones; go to DONE.
- FILL state:
  - Each cycle, drive pixel (cx,cy) with colour; vga_plot=plot bit AND on-screen.
  - count increments only when a pixel is actually plotted.
  - Raster order: cx steps up to x+w-1, then cx=x and cy steps up. Internal counters are one bit wider to avoid wrap.
  - After pixel (x+w-1, y+h-1): result<=count; go to DONE.
  - Duration is exactly w*h cycles.
- DONE, one cycle: vga_plot<=0, finished<=1, state<=IDLE.
- vga_plot is 0 in every cycle not listed above.
- Latency from accept edge to finished rising:
  - NOP/DRAW/RAND/unknown: 2 edges.
  - FILL: 2+w*h edges.
  - finished is therefore low at least 2 cycles, covering the initiator's delay and wait sampling.
- result holds its value until the next completion; finished stays high in IDLE.
- lfsr:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Shifts every cycle out of reset regardless of state; never zero.
- Simultaneous events:
  - A start rising edge in the same cycle as DONE is not accepted (state is not IDLE).
  - The initiator's minimum one-cycle start-low gap guarantees the next edge is seen.

Test Plan:
- Reset mid-FILL (w=20, h=10, at pixel 37) -> same cycle: finished=1, vga_plot=0, result=0; a following NOP completes normally.
- DRAW x=5, y=7, colour=3, plot=1 with start held 2 cycles -> vga_plot high exactly 1 cycle with (5,7,3); finished low 2 cycles; result=0; no second execution.
- Background-style sweep: 160*120 DRAW commands, each separated by the initiator's start/delay/wait cadence -> exactly 19200 vga_plot pulses covering each pixel once, in raster order.
- FILL x=158, y=118, w=4, h=4, plot=1 -> 16 FILL cycles; vga_plot high only for x in {158,159} and y in {118,119}; result=4.
- FILL w=0, h=5 -> no vga_plot pulses; result=0; finished back after 2 edges.
- RAND issued twice -> nonzero, differing results; opcode 9 -> result=32'hFFFFFFFF, no plots.
